// File: rtl/mult_booth_datapath_pkg.sv
// Shared multdiv definitions: default multiplier sizing and the Booth operation encoding
// used between the pair decoder and the accumulator datapath.
package mult_booth_datapath_pkg;

  localparam int MULT_WIDTH = 32;
  localparam int MULT_CNT_W = 6;

  typedef enum logic [1:0] {
    BOOTH_ADD  = 2'd0,
    BOOTH_SUB  = 2'd1,
    BOOTH_SKIP = 2'd2
  } booth_op_t;

  // skip outranks sub when the decoder drives an illegal pair
  function automatic booth_op_t booth_op_from_flags(input logic sub, input logic skip);
    if (skip)     return BOOTH_SKIP;
    else if (sub) return BOOTH_SUB;
    else          return BOOTH_ADD;
  endfunction

endpackage

// File: rtl/mult_booth_datapath_if.sv
// Operand/result bus of the Booth multiplier, including the Booth-pair decoder loop.
interface mult_booth_datapath_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_MULT;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [1:0]       booth_bits;
  logic             booth_sub;
  logic             booth_skip;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_MULT, data_operandA, data_operandB, booth_sub, booth_skip,
    input  booth_bits, data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_MULT, data_operandA, data_operandB, booth_sub, booth_skip,
    output booth_bits, data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/mult_booth_datapath_addsub.sv
// Accumulator update for one Booth step: add, subtract or pass the multiplicand.
module mult_booth_datapath_addsub
  import mult_booth_datapath_pkg::*;
#(
  parameter int W = 33
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  booth_op_t    op_i,
  output logic [W-1:0] y_o
);

  always_comb begin
    y_o = a_i;
    case (op_i)
      BOOTH_ADD: y_o = a_i + b_i;
      BOOTH_SUB: y_o = a_i - b_i;
      default:   y_o = a_i;
    endcase
  end

endmodule

// File: rtl/mult_booth_datapath.sv
// Sequential radix-2 Booth multiplier: one decoder-driven add/sub/skip plus arithmetic
// shift per cycle, WIDTH iterations, then a one-cycle ready pulse with product and overflow.
module mult_booth_datapath
  import mult_booth_datapath_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = MULT_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  mult_booth_datapath_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH+1:0] prod_q;
  logic [2*WIDTH+1:0] prod_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  logic [WIDTH-1:0]   result_q;
  logic               exc_q;
  logic               rdy_q;
  logic [WIDTH:0]     acc_n;
  logic               exc_d;

  mult_booth_datapath_addsub #(.W(WIDTH + 1)) u_addsub (
    .a_i  (prod_q[2*WIDTH+1:WIDTH+1]),
    .b_i  ({mcand_q[WIDTH-1], mcand_q}),
    .op_i (booth_op_from_flags(bus.booth_sub, bus.booth_skip)),
    .y_o  (acc_n)
  );

  // {acc_n, mplier, xbit} shifted right by one, sign taken from the new accumulator
  assign prod_d = {acc_n[WIDTH], acc_n, prod_q[WIDTH:1]};
  // product fits in WIDTH signed bits only if bits [2W-1:W-1] are all copies of the sign
  assign exc_d  = ~((&prod_d[2*WIDTH:WIDTH]) | ~(|prod_d[2*WIDTH:WIDTH]));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      if (bus.ctrl_MULT) begin
        state_q <= ST_RUN;
        mcand_q <= bus.data_operandA;
        prod_q  <= {{(WIDTH+1){1'b0}}, bus.data_operandB, 1'b0};
        cnt_q   <= '0;
        busy_q  <= 1'b1;
      end else if (state_q == ST_RUN) begin
        prod_q <= prod_d;
        cnt_q  <= cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
          result_q <= prod_d[WIDTH:1];
          exc_q    <= exc_d;
          rdy_q    <= 1'b1;
        end
      end
    end
  end

  assign bus.booth_bits     = prod_q[1:0];
  assign bus.data_result    = result_q;
  assign bus.data_exception = exc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_mult_booth_datapath.sv
// Scoreboard bench for the Booth multiplier with a behavioural Booth-pair decoder in the loop.
module tb_mult_booth_datapath;
  import mult_booth_datapath_pkg::*;

  localparam int W = 32;
  localparam int LAT = 32;

  typedef struct {
    logic [W-1:0] result;
    logic         exc;
    int           start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  mult_booth_datapath_if #(.WIDTH(W)) bus ();

  mult_booth_datapath #(.WIDTH(W), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Booth-pair decoder: 01 add, 10 subtract, 00/11 shift only
  always_comb begin
    bus.booth_sub  = 1'b0;
    bus.booth_skip = 1'b1;
    case (bus.booth_bits)
      2'b01: begin bus.booth_sub = 1'b0; bus.booth_skip = 1'b0; end
      2'b10: begin bus.booth_sub = 1'b1; bus.booth_skip = 1'b0; end
      default: begin bus.booth_sub = 1'b0; bus.booth_skip = 1'b1; end
    endcase
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // monitor: every ready pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.data_resultRDY === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rdy: got pulse at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", bus.data_result, e.result);
        check("exception", {31'b0, bus.data_exception}, {31'b0, e.exc});
        check("latency", W'(cyc - e.start_cyc), W'(LAT));
        check("busy_at_rdy", {31'b0, bus.busy}, 32'd0);
      end
    end
  end

  task automatic expect_op(input logic [W-1:0] res, input logic exc);
    exp_t e;
    e.result = res;
    e.exc = exc;
    e.start_cyc = cyc + 1;
    sb_q.push_back(e);
  endtask

  // caller is at a negedge; start takes effect on the next rising edge
  task automatic start_now(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.ctrl_MULT = 1'b1;
    bus.data_operandA = a;
    bus.data_operandB = b;
    @(posedge clk);
    #1 bus.ctrl_MULT = 1'b0;
  endtask

  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    start_now(a, b);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((sb_q.size() != 0 || bus.busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no completion in %0d cycles, expected ready", name, n);
    end
    @(negedge clk);
    check({name, "_busy_after"}, {31'b0, bus.busy}, 32'd0);
  endtask

  initial begin
    int n;
    bus.ctrl_MULT = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_result", bus.data_result, 32'd0);
    check("rst_exc", {31'b0, bus.data_exception}, 32'd0);
    check("rst_rdy", {31'b0, bus.data_resultRDY}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);

    // basic products and overflow cases
    @(negedge clk); expect_op(32'd12, 1'b0);        start_now(32'd3, 32'd4);
    check("busy_running", {31'b0, bus.busy}, 32'd1);
    wait_done("t1");
    @(negedge clk); expect_op(32'hFFFFFFD6, 1'b0);  start_now(32'hFFFFFFF9, 32'd6);
    wait_done("t2");
    @(negedge clk); expect_op(32'h80000000, 1'b1);  start_now(32'h80000000, 32'hFFFFFFFF);
    wait_done("t3a");
    @(negedge clk); expect_op(32'h00000000, 1'b1);  start_now(32'h00010000, 32'h00010000);
    wait_done("t3b");

    // restart while busy: only the second operation completes
    start_op(32'd5, 32'd5);
    repeat (9) @(negedge clk);
    expect_op(32'd18, 1'b0);
    start_now(32'd2, 32'd9);
    wait_done("t4");

    // reset mid-operation
    start_op(32'd7, 32'd7);
    repeat (14) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_result", bus.data_result, 32'd0);
    check("midrst_exc", {31'b0, bus.data_exception}, 32'd0);
    check("midrst_rdy", {31'b0, bus.data_resultRDY}, 32'd0);
    check("midrst_busy", {31'b0, bus.busy}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("postrst_busy", {31'b0, bus.busy}, 32'd0);

    // back-to-back: restart issued during the ready cycle
    @(negedge clk); expect_op(32'd42, 1'b0); start_now(32'd6, 32'd7);
    n = 0;
    while (bus.data_resultRDY !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL t6_timeout: got no ready in %0d cycles, expected ready", n);
    end
    expect_op(32'd1, 1'b0);
    start_now(32'hFFFFFFFF, 32'hFFFFFFFF);
    check("t6_hold_result", bus.data_result, 32'd42);
    check("t6_busy", {31'b0, bus.busy}, 32'd1);
    wait_done("t6");

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: got %0d pending, expected 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
